// File: rtl/instr_ctrl_unit.sv
// Fetch/decode/sequencing controller for the ALU datapath: owns the PC, the IR, the carry/borrow flags
// and the IDLE/FETCH/EXEC/MEM/WB/HALTED sequence, one instruction in flight at a time.
module instr_ctrl_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk_pi,
    input  logic        reset_pi,
    output logic        instr_req_po,
    output logic [15:0] pc_po,
    input  logic [15:0] instr_pi,
    input  logic        instr_valid_pi,
    output logic        arith_2op_po,
    output logic        arith_1op_po,
    output logic        addi_po,
    output logic        subi_po,
    output logic        load_or_store_po,
    output logic        stc_cmd_po,
    output logic        stb_cmd_po,
    output logic [2:0]  alu_func_po,
    output logic [5:0]  immediate_po,
    output logic        carry_in_po,
    output logic        borrow_in_po,
    input  logic        carry_out_pi,
    input  logic        borrow_out_pi,
    output logic [2:0]  rd_addr_po,
    output logic [2:0]  rs1_addr_po,
    output logic [2:0]  rs2_addr_po,
    output logic        reg_we_po,
    output logic [1:0]  wb_sel_po,
    output logic        mem_req_po,
    output logic        mem_we_po,
    input  logic        mem_ack_pi,
    input  logic        branch_taken_pi,
    output logic        halted_po
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        carry_q, carry_d;
    logic        borrow_q, borrow_d;

    logic        instr_req_q, reg_we_q, mem_req_q, mem_we_q, halted_q;
    logic [6:0]  strb_q, strb_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic [2:0]  func_q, rd_q, rs1_q, rs2_q;
    logic [5:0]  imm_q;

    logic [3:0]  op_d;
    logic [11:0] ctl_d;
    logic        dec_a2, dec_a1, dec_movi, dec_addi, dec_subi, dec_ld, dec_st;
    logic        dec_br, dec_j, dec_stc, dec_stb, dec_rst, dec_halt;
    logic        dec_we, dec_flags, active_d;
    logic [15:0] pc_inc, br_off, j_off;

    // Decode always looks at the IR value that will be held next cycle, so the
    // registered strobes line up with the state they belong to.
    assign ir_d  = (state_q == S_FETCH && instr_valid_pi) ? instr_pi : ir_q;
    assign op_d  = ir_d[15:12];
    assign ctl_d = ir_d[11:0];

    assign dec_a2   = (op_d == 4'h1);
    assign dec_a1   = (op_d == 4'h2);
    assign dec_movi = (op_d == 4'h3);
    assign dec_addi = (op_d == 4'h4);
    assign dec_subi = (op_d == 4'h5);
    assign dec_ld   = (op_d == 4'h6);
    assign dec_st   = (op_d == 4'h7);
    assign dec_br   = (op_d >= 4'h8) && (op_d <= 4'hB);
    assign dec_j    = (op_d == 4'hC);
    assign dec_stc  = (op_d == 4'hF) && (ctl_d == 12'h001);
    assign dec_stb  = (op_d == 4'hF) && (ctl_d == 12'h002);
    assign dec_rst  = (op_d == 4'hF) && (ctl_d == 12'hAAA);
    assign dec_halt = (op_d == 4'hF) && (ctl_d == 12'hFFF);

    assign dec_we    = dec_a2 | dec_a1 | dec_addi | dec_subi | dec_ld | dec_movi;
    assign dec_flags = dec_a2 | dec_a1 | dec_addi | dec_subi | dec_stc | dec_stb;
    assign strb_d    = {dec_a2, dec_a1, dec_addi, dec_subi, dec_ld | dec_st, dec_stc, dec_stb};
    assign wb_sel_d  = dec_ld ? 2'b01 : (dec_movi ? 2'b10 : 2'b00);

    assign pc_inc = pc_q + 16'd1;
    assign br_off = {{10{ir_d[5]}}, ir_d[5:0]};
    assign j_off  = {{4{ir_d[11]}}, ir_d[11:0]};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (instr_valid_pi) state_d = S_EXEC;
            S_EXEC:  state_d = (dec_ld | dec_st) ? S_MEM : S_WB;
            S_MEM:   if (mem_ack_pi) state_d = S_WB;
            S_WB: begin
                state_d = dec_halt ? S_HALTED : S_FETCH;
                pc_d    = pc_inc;
                if (dec_br && branch_taken_pi) pc_d = pc_inc + br_off;
                if (dec_j)                     pc_d = pc_inc + j_off;
                if (dec_flags) begin
                    carry_d  = carry_out_pi;
                    borrow_d = borrow_out_pi;
                end
                if (dec_rst) begin
                    pc_d     = RESET_PC;
                    carry_d  = 1'b0;
                    borrow_d = 1'b0;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    assign active_d = (state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_WB);

    // Outputs are registered from the next state so they are glitch-free and
    // still valid during the very cycle the state is entered.
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= 16'h0000;
            carry_q     <= 1'b0;
            borrow_q    <= 1'b0;
            instr_req_q <= 1'b0;
            reg_we_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            halted_q    <= 1'b0;
            strb_q      <= 7'd0;
            wb_sel_q    <= 2'b00;
            func_q      <= 3'd0;
            imm_q       <= 6'd0;
            rd_q        <= 3'd0;
            rs1_q       <= 3'd0;
            rs2_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            carry_q     <= carry_d;
            borrow_q    <= borrow_d;
            instr_req_q <= (state_d == S_FETCH);
            reg_we_q    <= (state_d == S_WB) && dec_we;
            mem_req_q   <= (state_d == S_MEM);
            mem_we_q    <= (state_d == S_MEM) && dec_st;
            halted_q    <= (state_d == S_HALTED);
            strb_q      <= active_d ? strb_d : 7'd0;
            wb_sel_q    <= active_d ? wb_sel_d : 2'b00;
            func_q      <= active_d ? ir_d[2:0] : 3'd0;
            imm_q       <= active_d ? ir_d[5:0] : 6'd0;
            rd_q        <= active_d ? ir_d[11:9] : 3'd0;
            rs1_q       <= active_d ? ir_d[8:6] : 3'd0;
            rs2_q       <= active_d ? ir_d[5:3] : 3'd0;
        end
    end

    assign instr_req_po     = instr_req_q;
    assign pc_po            = pc_q;
    assign arith_2op_po     = strb_q[6];
    assign arith_1op_po     = strb_q[5];
    assign addi_po          = strb_q[4];
    assign subi_po          = strb_q[3];
    assign load_or_store_po = strb_q[2];
    assign stc_cmd_po       = strb_q[1];
    assign stb_cmd_po       = strb_q[0];
    assign alu_func_po      = func_q;
    assign immediate_po     = imm_q;
    assign carry_in_po      = carry_q;
    assign borrow_in_po     = borrow_q;
    assign rd_addr_po       = rd_q;
    assign rs1_addr_po      = rs1_q;
    assign rs2_addr_po      = rs2_q;
    assign reg_we_po        = reg_we_q;
    assign wb_sel_po        = wb_sel_q;
    assign mem_req_po       = mem_req_q;
    assign mem_we_po        = mem_we_q;
    assign halted_po        = halted_q;

endmodule

// File: tb/tb_instr_ctrl_unit.sv
// Bench for instr_ctrl_unit: directed vector table, corner-case sequences and randomized
// instructions checked against an instruction-level reference model.
module tb_instr_ctrl_unit;

    localparam logic [15:0] RPC = 16'h0000;

    logic        clk_pi = 1'b0;
    logic        reset_pi = 1'b1;
    logic        instr_req_po;
    logic [15:0] pc_po;
    logic [15:0] instr_pi = 16'h0000;
    logic        instr_valid_pi = 1'b0;
    logic        arith_2op_po, arith_1op_po, addi_po, subi_po, load_or_store_po, stc_cmd_po, stb_cmd_po;
    logic [2:0]  alu_func_po;
    logic [5:0]  immediate_po;
    logic        carry_in_po, borrow_in_po;
    logic        carry_out_pi = 1'b0, borrow_out_pi = 1'b0;
    logic [2:0]  rd_addr_po, rs1_addr_po, rs2_addr_po;
    logic        reg_we_po;
    logic [1:0]  wb_sel_po;
    logic        mem_req_po, mem_we_po;
    logic        mem_ack_pi = 1'b0;
    logic        branch_taken_pi = 1'b0;
    logic        halted_po;

    instr_ctrl_unit #(.RESET_PC(RPC)) dut (
        .clk_pi(clk_pi), .reset_pi(reset_pi),
        .instr_req_po(instr_req_po), .pc_po(pc_po),
        .instr_pi(instr_pi), .instr_valid_pi(instr_valid_pi),
        .arith_2op_po(arith_2op_po), .arith_1op_po(arith_1op_po),
        .addi_po(addi_po), .subi_po(subi_po), .load_or_store_po(load_or_store_po),
        .stc_cmd_po(stc_cmd_po), .stb_cmd_po(stb_cmd_po),
        .alu_func_po(alu_func_po), .immediate_po(immediate_po),
        .carry_in_po(carry_in_po), .borrow_in_po(borrow_in_po),
        .carry_out_pi(carry_out_pi), .borrow_out_pi(borrow_out_pi),
        .rd_addr_po(rd_addr_po), .rs1_addr_po(rs1_addr_po), .rs2_addr_po(rs2_addr_po),
        .reg_we_po(reg_we_po), .wb_sel_po(wb_sel_po),
        .mem_req_po(mem_req_po), .mem_we_po(mem_we_po), .mem_ack_pi(mem_ack_pi),
        .branch_taken_pi(branch_taken_pi), .halted_po(halted_po)
    );

    always #5 clk_pi = ~clk_pi;

    int checks = 0;
    int failures = 0;

    // Architectural state as the bench believes it to be.
    logic [15:0] m_pc;
    logic        m_c, m_b;

    typedef struct {
        logic [6:0]  strb;
        logic        we;
        logic [1:0]  sel;
        logic        mem;
        logic        mem_we;
        logic [15:0] pc;
        logic        c, b, halt;
    } exp_t;

    typedef struct {
        logic [15:0] w;
        logic        tk, co, bo;
        int          ml;
        logic [15:0] pc;
        logic        c, b, we;
        logic [1:0]  sel;
        logic [6:0]  strb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Instruction-level behaviour: what one instruction does to PC, flags and the strobes.
    function automatic exp_t model(input logic [15:0] w, input logic [15:0] pc,
                                   input logic c, input logic b,
                                   input logic tk, input logic co, input logic bo);
        exp_t e;
        int   nxt;
        logic upd;
        int   off6, off12;
        e.strb = 7'd0; e.we = 1'b0; e.sel = 2'b00; e.mem = 1'b0; e.mem_we = 1'b0;
        e.halt = 1'b0; e.c = c; e.b = b;
        upd   = 1'b0;
        nxt   = int'(pc) + 1;
        off6  = w[5]  ? int'(w[5:0]) - 64    : int'(w[5:0]);
        off12 = w[11] ? int'(w[11:0]) - 4096 : int'(w[11:0]);
        case (w[15:12])
            4'h1: begin e.strb = 7'b1000000; e.we = 1'b1; upd = 1'b1; end
            4'h2: begin e.strb = 7'b0100000; e.we = 1'b1; upd = 1'b1; end
            4'h3: begin e.we = 1'b1; e.sel = 2'b10; end
            4'h4: begin e.strb = 7'b0010000; e.we = 1'b1; upd = 1'b1; end
            4'h5: begin e.strb = 7'b0001000; e.we = 1'b1; upd = 1'b1; end
            4'h6: begin e.strb = 7'b0000100; e.we = 1'b1; e.sel = 2'b01; e.mem = 1'b1; end
            4'h7: begin e.strb = 7'b0000100; e.mem = 1'b1; e.mem_we = 1'b1; end
            4'h8, 4'h9, 4'hA, 4'hB: if (tk) nxt = nxt + off6;
            4'hC: nxt = nxt + off12;
            4'hF: begin
                if (w[11:0] == 12'h001) begin e.strb = 7'b0000010; upd = 1'b1; end
                else if (w[11:0] == 12'h002) begin e.strb = 7'b0000001; upd = 1'b1; end
                else if (w[11:0] == 12'hAAA) begin nxt = int'(RPC); e.c = 1'b0; e.b = 1'b0; end
                else if (w[11:0] == 12'hFFF) e.halt = 1'b1;
            end
            default: ;
        endcase
        if (upd) begin e.c = co; e.b = bo; end
        e.pc = nxt[15:0];
        return e;
    endfunction

    task automatic do_reset();
        reset_pi = 1'b1;
        instr_valid_pi = 1'b0; mem_ack_pi = 1'b0;
        repeat (2) @(negedge clk_pi);
        chk("reset_pc", 32'(pc_po), 32'(RPC));
        chk("reset_outs", 32'({instr_req_po, arith_2op_po, arith_1op_po, addi_po, subi_po,
                              load_or_store_po, stc_cmd_po, stb_cmd_po, reg_we_po, wb_sel_po,
                              mem_req_po, mem_we_po, halted_po, carry_in_po, borrow_in_po}), 32'd0);
        chk("reset_fields", 32'({alu_func_po, immediate_po, rd_addr_po, rs1_addr_po, rs2_addr_po}), 32'd0);
        reset_pi = 1'b0;
        m_pc = RPC; m_c = 1'b0; m_b = 1'b0;
    endtask

    task automatic run_instr(input logic [15:0] w, input logic tk, input logic co, input logic bo,
                             input int ml, output logic cap_we, output logic [1:0] cap_sel,
                             output logic [6:0] cap_strb);
        exp_t e;
        int   n;
        int   mcnt;
        e = model(w, m_pc, m_c, m_b, tk, co, bo);
        n = 0;
        while (instr_req_po !== 1'b1 && n < 20) begin
            @(negedge clk_pi);
            n++;
        end
        chk("fetch_req", 32'(instr_req_po), 32'd1);
        chk("fetch_pc", 32'(pc_po), 32'(m_pc));
        instr_pi = w; instr_valid_pi = 1'b1;
        branch_taken_pi = tk; carry_out_pi = co; borrow_out_pi = bo;
        @(negedge clk_pi);
        instr_valid_pi = 1'b0;
        instr_pi = 16'($urandom);
        cap_strb = {arith_2op_po, arith_1op_po, addi_po, subi_po, load_or_store_po, stc_cmd_po, stb_cmd_po};
        chk("exec_strobes", 32'(cap_strb), 32'(e.strb));
        chk("exec_fields", 32'({alu_func_po, immediate_po, rd_addr_po, rs1_addr_po, rs2_addr_po}),
            32'({w[2:0], w[5:0], w[11:9], w[8:6], w[5:3]}));
        chk("exec_quiet", 32'({instr_req_po, reg_we_po, mem_req_po}), 32'd0);
        @(negedge clk_pi);
        if (e.mem) begin
            mcnt = 0;
            while (mem_req_po === 1'b1 && mcnt < ml + 5) begin
                chk("mem_we", 32'(mem_we_po), 32'(e.mem_we));
                mcnt++;
                if (mcnt == ml) mem_ack_pi = 1'b1;
                @(negedge clk_pi);
                mem_ack_pi = 1'b0;
            end
            chk("mem_cycles", 32'(mcnt), 32'(ml));
        end
        cap_we  = reg_we_po;
        cap_sel = wb_sel_po;
        chk("wb_we_sel", 32'({reg_we_po, wb_sel_po, mem_req_po}), 32'({e.we, e.sel, 1'b0}));
        @(negedge clk_pi);
        chk("next_pc", 32'(pc_po), 32'(e.pc));
        chk("flags", 32'({carry_in_po, borrow_in_po}), 32'({e.c, e.b}));
        chk("halted", 32'(halted_po), 32'(e.halt));
        chk("post_wb", 32'({reg_we_po, instr_req_po}), 32'({1'b0, ~e.halt}));
        m_pc = e.pc; m_c = e.c; m_b = e.b;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[14];
        logic        we;
        logic [1:0]  sel;
        logic [6:0]  strb;
        logic [3:0]  op;
        logic [11:0] cc;
        logic [15:0] w;

        tbl[0]  = '{16'h1A50, 1'b0, 1'b0, 1'b1, 1, 16'h0001, 1'b0, 1'b1, 1'b1, 2'd0, 7'b1000000};
        tbl[1]  = '{16'hF001, 1'b0, 1'b1, 1'b0, 1, 16'h0002, 1'b1, 1'b0, 1'b0, 2'd0, 7'b0000010};
        tbl[2]  = '{16'h3000, 1'b0, 1'b0, 1'b1, 1, 16'h0003, 1'b1, 1'b0, 1'b1, 2'd2, 7'b0000000};
        tbl[3]  = '{16'h6283, 1'b0, 1'b0, 1'b1, 2, 16'h0004, 1'b1, 1'b0, 1'b1, 2'd1, 7'b0000100};
        tbl[4]  = '{16'h7283, 1'b0, 1'b0, 1'b0, 1, 16'h0005, 1'b1, 1'b0, 1'b0, 2'd0, 7'b0000100};
        tbl[5]  = '{16'h4041, 1'b0, 1'b0, 1'b0, 1, 16'h0006, 1'b0, 1'b0, 1'b1, 2'd0, 7'b0010000};
        tbl[6]  = '{16'h8003, 1'b1, 1'b1, 1'b1, 1, 16'h000A, 1'b0, 1'b0, 1'b0, 2'd0, 7'b0000000};
        tbl[7]  = '{16'hC002, 1'b0, 1'b0, 1'b0, 1, 16'h000D, 1'b0, 1'b0, 1'b0, 2'd0, 7'b0000000};
        tbl[8]  = '{16'hD123, 1'b1, 1'b1, 1'b1, 1, 16'h000E, 1'b0, 1'b0, 1'b0, 2'd0, 7'b0000000};
        tbl[9]  = '{16'hF123, 1'b1, 1'b1, 1'b1, 1, 16'h000F, 1'b0, 1'b0, 1'b0, 2'd0, 7'b0000000};
        tbl[10] = '{16'h5000, 1'b0, 1'b1, 1'b1, 1, 16'h0010, 1'b1, 1'b1, 1'b1, 2'd0, 7'b0001000};
        tbl[11] = '{16'hFAAA, 1'b0, 1'b1, 1'b1, 1, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 7'b0000000};
        tbl[12] = '{16'h2040, 1'b0, 1'b1, 1'b0, 1, 16'h0001, 1'b1, 1'b0, 1'b1, 2'd0, 7'b0100000};
        tbl[13] = '{16'hF002, 1'b0, 1'b0, 1'b1, 1, 16'h0002, 1'b0, 1'b1, 1'b0, 2'd0, 7'b0000001};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            run_instr(tbl[i].w, tbl[i].tk, tbl[i].co, tbl[i].bo, tbl[i].ml, we, sel, strb);
            chk("tbl_pc", 32'(pc_po), 32'(tbl[i].pc));
            chk("tbl_flags", 32'({carry_in_po, borrow_in_po}), 32'({tbl[i].c, tbl[i].b}));
            chk("tbl_we_sel_strb", 32'({we, sel, strb}), 32'({tbl[i].we, tbl[i].sel, tbl[i].strb}));
        end

        // Branch offsets, not-taken branch and PC wraparound.
        do_reset();
        run_instr(16'hC00F, 1'b0, 1'b0, 1'b0, 1, we, sel, strb);
        chk("jmp_to_0010", 32'(pc_po), 32'h0010);
        run_instr(16'h803E, 1'b1, 1'b0, 1'b0, 1, we, sel, strb);
        chk("beq_taken_back", 32'(pc_po), 32'h000F);
        run_instr(16'h0000, 1'b0, 1'b0, 1'b0, 1, we, sel, strb);
        run_instr(16'h803E, 1'b0, 1'b0, 1'b0, 1, we, sel, strb);
        chk("beq_not_taken", 32'(pc_po), 32'h0011);
        run_instr(16'hCFED, 1'b0, 1'b0, 1'b0, 1, we, sel, strb);
        chk("jmp_to_ffff", 32'(pc_po), 32'hFFFF);
        run_instr(16'hC001, 1'b0, 1'b0, 1'b0, 1, we, sel, strb);
        chk("jmp_wrap", 32'(pc_po), 32'h0001);

        // Slow memory: request held for the whole wait.
        run_instr(16'h6283, 1'b0, 1'b0, 1'b0, 4, we, sel, strb);
        chk("load_slow_wb", 32'({we, sel}), 32'({1'b1, 2'b01}));

        // HALT stays halted without fetching.
        run_instr(16'hFFFF, 1'b0, 1'b0, 1'b0, 1, we, sel, strb);
        begin
            int req_seen;
            req_seen = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk_pi);
                if (instr_req_po !== 1'b0 || halted_po !== 1'b1) req_seen++;
            end
            chk("halt_20_cycles", 32'(req_seen), 32'd0);
        end

        // Asynchronous reset in the middle of a memory wait.
        do_reset();
        chk("halt_cleared", 32'(halted_po), 32'd0);
        begin
            int n;
            n = 0;
            while (instr_req_po !== 1'b1 && n < 20) begin
                @(negedge clk_pi);
                n++;
            end
            instr_pi = 16'h7283; instr_valid_pi = 1'b1;
            @(negedge clk_pi);
            instr_valid_pi = 1'b0;
            @(negedge clk_pi);
            chk("mid_mem_req", 32'({mem_req_po, mem_we_po}), 32'b11);
            #2 reset_pi = 1'b1;
            #1;
            chk("async_drop", 32'({mem_req_po, mem_we_po, load_or_store_po, instr_req_po}), 32'd0);
            chk("async_pc", 32'(pc_po), 32'(RPC));
            @(negedge clk_pi);
            reset_pi = 1'b0;
            n = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk_pi);
                if (mem_req_po !== 1'b0 || reg_we_po !== 1'b0) n++;
            end
            chk("no_req_after_reset", 32'(n), 32'd0);
            m_pc = RPC; m_c = 1'b0; m_b = 1'b0;
        end
        run_instr(16'h1A50, 1'b0, 1'b1, 1'b1, 1, we, sel, strb);

        // Randomized instruction stream.
        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            cc = 12'($urandom);
            if (op == 4'hF) begin
                case ($urandom_range(0, 3))
                    0: cc = 12'h001;
                    1: cc = 12'h002;
                    2: cc = ($urandom_range(0, 3) == 0) ? 12'hAAA : 12'h001;
                    default: if (cc == 12'hFFF) cc = 12'h123;
                endcase
            end
            w = {op, cc};
            run_instr(w, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, 4), we, sel, strb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
